// File: rtl/issue_queue_if.sv
// issue_queue_if
// Groups the decode-side micro-op bus, with its busy-table lookup bits, and
// the issue-side output bus of the issue queue into one bundle.
//   slave  : the issue queue's view. It receives DC_* and rs*_busy, and
//            drives IS_ready and IS_out_*.
//   master : the surrounding pipeline's view (decode / register read).
// Wakeup, FU availability, flush, hold and IS_count stay plain ports on the
// queue module.
interface issue_queue_if;
  // Decode / rename side
  logic        DC_valid;
  logic [31:0] DC_out_pc;
  logic [31:0] DC_out_inst;
  logic [31:0] DC_out_imm;
  logic [4:0]  DC_out_op;
  logic [2:0]  DC_out_f3;
  logic [6:0]  DC_out_f7;
  logic [6:0]  DC_out_P_rs1;
  logic [6:0]  DC_out_P_rs2;
  logic [6:0]  DC_out_P_rd;
  logic [2:0]  DC_out_fu_sel;
  logic [2:0]  DC_out_rob_idx;
  logic [1:0]  DC_out_LQ_tail;
  logic [1:0]  DC_out_SQ_tail;
  logic        DC_out_jump;
  logic        rs1_busy;
  logic        rs2_busy;

  // Issue side
  logic        IS_ready;
  logic        IS_out_valid;
  logic [31:0] IS_out_pc;
  logic [31:0] IS_out_inst;
  logic [31:0] IS_out_imm;
  logic [4:0]  IS_out_op;
  logic [2:0]  IS_out_f3;
  logic [6:0]  IS_out_f7;
  logic [6:0]  IS_out_P_rs1;
  logic [6:0]  IS_out_P_rs2;
  logic [6:0]  IS_out_P_rd;
  logic [2:0]  IS_out_fu_sel;
  logic [2:0]  IS_out_rob_idx;
  logic [1:0]  IS_out_LQ_tail;
  logic [1:0]  IS_out_SQ_tail;
  logic        IS_out_jump;

  modport master (
    output DC_valid, DC_out_pc, DC_out_inst, DC_out_imm, DC_out_op, DC_out_f3,
           DC_out_f7, DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd, DC_out_fu_sel,
           DC_out_rob_idx, DC_out_LQ_tail, DC_out_SQ_tail, DC_out_jump,
           rs1_busy, rs2_busy,
    input  IS_ready, IS_out_valid, IS_out_pc, IS_out_inst, IS_out_imm,
           IS_out_op, IS_out_f3, IS_out_f7, IS_out_P_rs1, IS_out_P_rs2,
           IS_out_P_rd, IS_out_fu_sel, IS_out_rob_idx, IS_out_LQ_tail,
           IS_out_SQ_tail, IS_out_jump
  );

  modport slave (
    input  DC_valid, DC_out_pc, DC_out_inst, DC_out_imm, DC_out_op, DC_out_f3,
           DC_out_f7, DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd, DC_out_fu_sel,
           DC_out_rob_idx, DC_out_LQ_tail, DC_out_SQ_tail, DC_out_jump,
           rs1_busy, rs2_busy,
    output IS_ready, IS_out_valid, IS_out_pc, IS_out_inst, IS_out_imm,
           IS_out_op, IS_out_f3, IS_out_f7, IS_out_P_rs1, IS_out_P_rs2,
           IS_out_P_rd, IS_out_fu_sel, IS_out_rob_idx, IS_out_LQ_tail,
           IS_out_SQ_tail, IS_out_jump
  );
endinterface

// File: rtl/issue_queue.sv
// issue_queue
// Unified issue queue with in-order age. Slot 0 always holds the oldest
// entry. It accepts one renamed micro-op per cycle and tracks source
// readiness from the busy table at insert and from writeback wakeups
// afterwards. Each cycle it issues the oldest ready entry whose FU class is
// free into a registered output.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   iq (slave)   : decode micro-op bus and busy bits in; IS_ready and
//                  registered IS_out_* bus out
//   wb_valid     : per-port wakeup valid
//   wb_preg      : woken physical register per port, port k at [7k+6:7k]
//   fu_ready     : bit n set means FU class n can accept this cycle
//   mispredict   : full flush, takes priority over stall
//   stall        : global hold. Wakeups are still applied.
//   IS_count     : number of occupied entries (registered)
module issue_queue #(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  issue_queue_if.slave                 iq,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [7*WB_PORTS-1:0]        wb_preg,
  input  logic [7:0]                   fu_ready,
  input  logic                         mispredict,
  input  logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   IS_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  prs1;
    logic [6:0]  prs2;
    logic [6:0]  prd;
    logic [2:0]  fu_sel;
    logic [2:0]  rob_idx;
    logic [1:0]  lq_tail;
    logic [1:0]  sq_tail;
    logic        jump;
    logic        rdy1;
    logic        rdy2;
  } entry_t;

  entry_t             slot_q   [DEPTH];
  entry_t             slot_d   [DEPTH];
  entry_t             woken    [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic [CW-1:0]      ins_pos;
  entry_t             new_entry;
  entry_t             out_q;
  logic               out_valid_q;
  logic               is_ready;
  logic               sel_found;
  logic [IW-1:0]      sel_idx;
  logic               do_issue;
  logic               do_insert;

  // Returns true when any valid writeback port broadcasts the given
  // physical register.
  function automatic logic wb_hit(input logic [6:0] preg,
                                  input logic [WB_PORTS-1:0] wv,
                                  input logic [7*WB_PORTS-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wv[k] && (wp[7*k +: 7] == preg)) hit = 1'b1;
    end
    return hit;
  endfunction

  // IS_ready uses only the registered count and the flush/hold inputs, so a
  // full queue stays closed even in a cycle where an entry issues.
  assign is_ready    = (count_q < CW'(DEPTH)) && !mispredict && !stall;
  assign iq.IS_ready = is_ready;
  assign IS_count    = count_q;

  // Select the oldest entry that is ready and whose FU is free. Only
  // registered readiness is used, so same-cycle wakeups and fresh inserts
  // wait a cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && valid_q[i] && slot_q[i].rdy1 && slot_q[i].rdy2 &&
          fu_ready[slot_q[i].fu_sel]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign do_issue  = sel_found && !mispredict && !stall;
  assign do_insert = iq.DC_valid && is_ready;
  assign ins_pos   = count_q - CW'(do_issue);

  // Build the incoming entry. Preg 0 and a same-cycle writeback both count
  // as ready, so an operand produced this cycle is not missed.
  always_comb begin
    new_entry         = '0;
    new_entry.pc      = iq.DC_out_pc;
    new_entry.inst    = iq.DC_out_inst;
    new_entry.imm     = iq.DC_out_imm;
    new_entry.op      = iq.DC_out_op;
    new_entry.f3      = iq.DC_out_f3;
    new_entry.f7      = iq.DC_out_f7;
    new_entry.prs1    = iq.DC_out_P_rs1;
    new_entry.prs2    = iq.DC_out_P_rs2;
    new_entry.prd     = iq.DC_out_P_rd;
    new_entry.fu_sel  = iq.DC_out_fu_sel;
    new_entry.rob_idx = iq.DC_out_rob_idx;
    new_entry.lq_tail = iq.DC_out_LQ_tail;
    new_entry.sq_tail = iq.DC_out_SQ_tail;
    new_entry.jump    = iq.DC_out_jump;
    new_entry.rdy1    = !iq.rs1_busy || (iq.DC_out_P_rs1 == 7'd0) ||
                        wb_hit(iq.DC_out_P_rs1, wb_valid, wb_preg);
    new_entry.rdy2    = !iq.rs2_busy || (iq.DC_out_P_rs2 == 7'd0) ||
                        wb_hit(iq.DC_out_P_rs2, wb_valid, wb_preg);
  end

  // Apply this cycle's wakeups to every stored entry. This also happens
  // during stall.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = slot_q[i];
      if (wb_hit(slot_q[i].prs1, wb_valid, wb_preg)) woken[i].rdy1 = 1'b1;
      if (wb_hit(slot_q[i].prs2, wb_valid, wb_preg)) woken[i].rdy2 = 1'b1;
    end
  end

  // Compute the next array state. On issue, slots above the selected one
  // move down by one. The new micro-op then goes into the first free slot
  // after that move. A mispredict overrides everything by dropping all
  // valids.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i]  = woken[i];
      valid_d[i] = valid_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_issue && (IW'(i) >= sel_idx)) begin
        slot_d[i]  = woken[i+1];
        valid_d[i] = valid_q[i+1];
      end
    end
    if (do_issue) valid_d[DEPTH-1] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_insert && (CW'(i) == ins_pos)) begin
        slot_d[i]  = new_entry;
        valid_d[i] = 1'b1;
      end
    end
    if (mispredict) valid_d = '0;

    count_d = count_q + CW'(do_insert) - CW'(do_issue);
    if (mispredict) count_d = '0;
  end

  // Queue storage and occupancy registers. Reset behaves like a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Issue output register. The data holds when nothing issues, and is
  // cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= do_issue;
      if (do_issue) out_q <= slot_q[sel_idx];
    end
  end

  assign iq.IS_out_valid   = out_valid_q;
  assign iq.IS_out_pc      = out_q.pc;
  assign iq.IS_out_inst    = out_q.inst;
  assign iq.IS_out_imm     = out_q.imm;
  assign iq.IS_out_op      = out_q.op;
  assign iq.IS_out_f3      = out_q.f3;
  assign iq.IS_out_f7      = out_q.f7;
  assign iq.IS_out_P_rs1   = out_q.prs1;
  assign iq.IS_out_P_rs2   = out_q.prs2;
  assign iq.IS_out_P_rd    = out_q.prd;
  assign iq.IS_out_fu_sel  = out_q.fu_sel;
  assign iq.IS_out_rob_idx = out_q.rob_idx;
  assign iq.IS_out_LQ_tail = out_q.lq_tail;
  assign iq.IS_out_SQ_tail = out_q.sq_tail;
  assign iq.IS_out_jump    = out_q.jump;

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue
// Testbench for issue_queue with a scoreboard. The stimulus side drives one
// set of inputs per cycle and steps a queue-based reference model. Each op
// the model issues is pushed into a scoreboard. A separate monitor pops and
// compares whenever the DUT presents IS_out_valid. The bench runs a handful
// of directed scenarios, then a long randomized run.
module tb_issue_queue;

  localparam int DEPTH    = 4;
  localparam int WB_PORTS = 2;
  localparam int CW       = $clog2(DEPTH+1);

  typedef struct {
    logic [31:0] pc, inst, imm;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  rs1, rs2, rd;
    logic [2:0]  fu, rob;
    logic [1:0]  lq, sq;
    logic        jump;
  } uop_t;

  typedef struct {
    uop_t u;
    bit   r1, r2;
  } ment_t;

  typedef struct {
    bit         dcv;
    uop_t       u;
    bit         b1, b2;
    logic [1:0] wbv;
    logic [6:0] wbp0, wbp1;
    logic [7:0] fur;
    bit         mp, st;
  } stim_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [WB_PORTS-1:0]   wb_valid = '0;
  logic [7*WB_PORTS-1:0] wb_preg = '0;
  logic [7:0]            fu_ready = 8'hFF;
  logic                  mispredict = 1'b0;
  logic                  stall = 1'b0;
  logic [CW-1:0]         IS_count;

  issue_queue_if iq_if();

  issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
    .clk        (clk),
    .rst        (rst),
    .iq         (iq_if.slave),
    .wb_valid   (wb_valid),
    .wb_preg    (wb_preg),
    .fu_ready   (fu_ready),
    .mispredict (mispredict),
    .stall      (stall),
    .IS_count   (IS_count)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  bit    running  = 0;
  bit    exp_valid = 0;
  ment_t mq[$];
  uop_t  sb[$];

  // Compares one value and reports a mismatch on a single FAIL line.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit wbHit(input stim_t s, input logic [6:0] p);
    return (s.wbv[0] && s.wbp0 == p) || (s.wbv[1] && s.wbp1 == p);
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    s.u = '{default: '0};
    s.fur = 8'hFF;
    return s;
  endfunction

  function automatic stim_t mkOp(input logic [31:0] pc, input logic [6:0] rs1,
                                 input logic [6:0] rs2, input bit b1, input bit b2,
                                 input logic [2:0] fu);
    stim_t s;
    s = idleStim();
    s.dcv    = 1;
    s.u.pc   = pc;
    s.u.inst = pc ^ 32'h00A5_0033;
    s.u.imm  = {16'h0, pc[15:0]} + 32'd7;
    s.u.op   = pc[6:2];
    s.u.f3   = pc[2:0] + 3'd1;
    s.u.f7   = pc[8:2];
    s.u.rs1  = rs1;
    s.u.rs2  = rs2;
    s.u.rd   = pc[6:0] + 7'd3;
    s.u.fu   = fu;
    s.u.rob  = pc[4:2];
    s.u.lq   = pc[3:2];
    s.u.sq   = pc[5:4];
    s.u.jump = pc[2];
    s.b1     = b1;
    s.b2     = b2;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s = mkOp($urandom, 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)));
    s.u.inst = $urandom;
    s.u.imm  = $urandom;
    s.u.rd   = 7'($urandom);
    s.u.rob  = 3'($urandom);
    s.dcv    = ($urandom_range(0, 3) != 0);
    s.wbv    = 2'($urandom_range(0, 3));
    s.wbp0   = 7'($urandom_range(0, 15));
    s.wbp1   = 7'($urandom_range(0, 15));
    s.fur    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
    s.mp     = ($urandom_range(0, 60) == 0);
    s.st     = ($urandom_range(0, 10) == 0);
    return s;
  endfunction

  // Drives one cycle of inputs. It checks IS_ready and IS_count against the
  // model, then advances the model through the upcoming edge. Rules: flush
  // empties everything. Otherwise the oldest ready op with a free FU leaves,
  // survivors see wakeups, and an accepted op joins at the back.
  task automatic applyStimulus(input stim_t s);
    int    found;
    bit    ready;
    ment_t e;
    @(negedge clk);
    iq_if.DC_valid       = s.dcv;
    iq_if.DC_out_pc      = s.u.pc;
    iq_if.DC_out_inst    = s.u.inst;
    iq_if.DC_out_imm     = s.u.imm;
    iq_if.DC_out_op      = s.u.op;
    iq_if.DC_out_f3      = s.u.f3;
    iq_if.DC_out_f7      = s.u.f7;
    iq_if.DC_out_P_rs1   = s.u.rs1;
    iq_if.DC_out_P_rs2   = s.u.rs2;
    iq_if.DC_out_P_rd    = s.u.rd;
    iq_if.DC_out_fu_sel  = s.u.fu;
    iq_if.DC_out_rob_idx = s.u.rob;
    iq_if.DC_out_LQ_tail = s.u.lq;
    iq_if.DC_out_SQ_tail = s.u.sq;
    iq_if.DC_out_jump    = s.u.jump;
    iq_if.rs1_busy       = s.b1;
    iq_if.rs2_busy       = s.b2;
    wb_valid             = s.wbv;
    wb_preg              = {s.wbp1, s.wbp0};
    fu_ready             = s.fur;
    mispredict           = s.mp;
    stall                = s.st;
    #1;
    ready = (mq.size() < DEPTH) && !s.mp && !s.st;
    checkOutput("is_ready", 64'(iq_if.IS_ready), 64'(ready));
    checkOutput("is_count", 64'(IS_count), 64'(mq.size()));

    if (s.mp) begin
      mq.delete();
      exp_valid = 0;
    end else begin
      found = -1;
      if (!s.st) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].r1 && mq[i].r2 && s.fur[mq[i].u.fu]) begin
            found = i;
            break;
          end
        end
      end
      if (found >= 0) begin
        sb.push_back(mq[found].u);
        mq.delete(found);
      end
      foreach (mq[i]) begin
        if (wbHit(s, mq[i].u.rs1)) mq[i].r1 = 1;
        if (wbHit(s, mq[i].u.rs2)) mq[i].r2 = 1;
      end
      if (s.dcv && ready) begin
        e.u  = s.u;
        e.r1 = !s.b1 || (s.u.rs1 == 0) || wbHit(s, s.u.rs1);
        e.r2 = !s.b2 || (s.u.rs2 == 0) || wbHit(s, s.u.rs2);
        mq.push_back(e);
      end
      exp_valid = (found >= 0);
    end
    @(posedge clk);
  endtask

  // Monitor: just after each edge, check IS_out_valid against the model.
  // When the DUT issues, pop the oldest scoreboard entry and compare all
  // output fields against it.
  initial begin
    uop_t u;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        checkOutput("out_valid", 64'(iq_if.IS_out_valid), 64'(exp_valid));
        if (iq_if.IS_out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected: DUT issued pc 0x%0h, none expected at %0t",
                     iq_if.IS_out_pc, $time);
          end else begin
            u = sb.pop_front();
            checkOutput("out_pc", 64'(iq_if.IS_out_pc), 64'(u.pc));
            checkOutput("out_inst_imm", {iq_if.IS_out_inst, iq_if.IS_out_imm},
                        {u.inst, u.imm});
            checkOutput("out_fields",
              64'({iq_if.IS_out_op, iq_if.IS_out_f3, iq_if.IS_out_f7,
                   iq_if.IS_out_P_rs1, iq_if.IS_out_P_rs2, iq_if.IS_out_P_rd,
                   iq_if.IS_out_fu_sel, iq_if.IS_out_rob_idx, iq_if.IS_out_LQ_tail,
                   iq_if.IS_out_SQ_tail, iq_if.IS_out_jump}),
              64'({u.op, u.f3, u.f7, u.rs1, u.rs2, u.rd, u.fu, u.rob, u.lq,
                   u.sq, u.jump}));
          end
        end
      end
    end
  end

  // Main sequence: reset, directed scenarios, random run, mid-run reset,
  // then the summary line.
  initial begin
    stim_t s;
    applyIdleInputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_count", 64'(IS_count), 64'(0));
    checkOutput("rst_out_valid", 64'(iq_if.IS_out_valid), 64'(0));
    checkOutput("rst_ready", 64'(iq_if.IS_ready), 64'(1));
    checkOutput("rst_out_pc", 64'(iq_if.IS_out_pc), 64'(0));
    running = 1;

    // Single ready add: it issues on the second edge after it is offered.
    applyStimulus(mkOp(32'h100, 7'd5, 7'd6, 0, 0, 3'd0));
    repeat (3) applyStimulus(idleStim());

    // Fill with ops waiting on preg 9, then wake them and drain in age order.
    for (int i = 0; i < 5; i++) applyStimulus(mkOp(32'h200 + 32'(4*i), 7'd9, 7'd0, 1, 0, 3'd1));
    s = idleStim(); s.wbv = 2'b01; s.wbp0 = 7'd9;
    applyStimulus(s);
    repeat (6) applyStimulus(idleStim());

    // Oldest op blocked on a busy FU class 2; a younger FU0 op overtakes it.
    s = mkOp(32'h300, 7'd1, 7'd2, 0, 0, 3'd2); s.fur = 8'hFB; applyStimulus(s);
    s = mkOp(32'h304, 7'd1, 7'd2, 0, 0, 3'd0); s.fur = 8'hFB; applyStimulus(s);
    repeat (3) begin s = idleStim(); s.fur = 8'hFB; applyStimulus(s); end
    repeat (3) applyStimulus(idleStim());

    // Insert-time bypass from writeback port 1, and preg 0 always ready.
    s = mkOp(32'h400, 7'd0, 7'd12, 1, 1, 3'd3); s.wbv = 2'b10; s.wbp1 = 7'd12;
    applyStimulus(s);
    repeat (3) applyStimulus(idleStim());

    // Flush with three queued ops while a new op is offered.
    for (int i = 0; i < 3; i++) applyStimulus(mkOp(32'h500 + 32'(4*i), 7'd20, 7'd0, 1, 0, 3'd0));
    s = mkOp(32'h50C, 7'd0, 7'd0, 0, 0, 3'd0); s.mp = 1; applyStimulus(s);
    repeat (3) applyStimulus(idleStim());

    // Stall for three cycles with a wakeup in the middle; drain afterwards.
    for (int i = 0; i < 3; i++) applyStimulus(mkOp(32'h600 + 32'(4*i), 7'd9, 7'd0, 1, 0, 3'd0));
    s = idleStim(); s.st = 1; applyStimulus(s);
    s.wbv = 2'b01; s.wbp0 = 7'd9; applyStimulus(s);
    s = idleStim(); s.st = 1; applyStimulus(s);
    repeat (5) applyStimulus(idleStim());

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) applyStimulus(randStim());

    // Reset in mid-operation: queue and output data must both clear.
    for (int i = 0; i < 3; i++) applyStimulus(mkOp(32'h700 + 32'(4*i), 7'd0, 7'd0, 0, 0, 3'd0));
    @(negedge clk);
    applyIdleInputs();
    rst = 1'b1;
    exp_valid = 0;
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_count", 64'(IS_count), 64'(0));
    checkOutput("midrst_out_pc", 64'(iq_if.IS_out_pc), 64'(0));
    checkOutput("midrst_ready", 64'(iq_if.IS_ready), 64'(1));
    checkOutput("sb_drained", 64'(sb.size()), 64'(0));
    repeat (2) applyStimulus(idleStim());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic applyIdleInputs();
    iq_if.DC_valid       = 1'b0;
    iq_if.DC_out_pc      = '0;
    iq_if.DC_out_inst    = '0;
    iq_if.DC_out_imm     = '0;
    iq_if.DC_out_op      = '0;
    iq_if.DC_out_f3      = '0;
    iq_if.DC_out_f7      = '0;
    iq_if.DC_out_P_rs1   = '0;
    iq_if.DC_out_P_rs2   = '0;
    iq_if.DC_out_P_rd    = '0;
    iq_if.DC_out_fu_sel  = '0;
    iq_if.DC_out_rob_idx = '0;
    iq_if.DC_out_LQ_tail = '0;
    iq_if.DC_out_SQ_tail = '0;
    iq_if.DC_out_jump    = 1'b0;
    iq_if.rs1_busy       = 1'b0;
    iq_if.rs2_busy       = 1'b0;
    wb_valid             = '0;
    wb_preg              = '0;
    fu_ready             = 8'hFF;
    mispredict           = 1'b0;
    stall                = 1'b0;
  endtask

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
Unified in-order-aged issue queue sitting directly downstream of the decode/rename stage. It accepts one renamed micro-op per cycle, tracks source-operand readiness via busy-table lookup at insert and writeback wakeups, and selects the oldest ready entry whose functional unit is free. It issues that entry into a registered output toward register read / execute, and flushes completely on mispredict.

Parameters:
DEPTH, 4, number of queue entries (power of 2 not required; 2..8 supported)
WB_PORTS, 2, number of writeback wakeup ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
DC_valid  in  1  decode stage holds a valid micro-op
DC_out_pc  in  32  micro-op pc
DC_out_inst  in  32  raw instruction
DC_out_imm  in  32  decoded immediate
DC_out_op  in  5  opcode[6:2]
DC_out_f3  in  3  funct3
DC_out_f7  in  7  funct7
DC_out_P_rs1  in  7  physical src1
DC_out_P_rs2  in  7  physical src2
DC_out_P_rd  in  7  physical dest
DC_out_fu_sel  in  3  FU class 0..7
DC_out_rob_idx  in  3  ROB index
DC_out_LQ_tail  in  2  load queue tail snapshot
DC_out_SQ_tail  in  2  store queue tail snapshot
DC_out_jump  in  1  predicted-taken flag
rs1_busy  in  1  busy-table bit for DC_out_P_rs1 (combinational lookup)
rs2_busy  in  1  busy-table bit for DC_out_P_rs2
wb_valid  in  WB_PORTS  wakeup valid per port
wb_preg  in  7*WB_PORTS  woken physical reg per port, port k at [7k+6:7k]
fu_ready  in  8  bit n high: FU class n can accept this cycle
mispredict  in  1  flush
stall  in  1  global hold
IS_ready  out  1  queue can accept this cycle
IS_count  out  $clog2(DEPTH+1)  occupied entries
IS_out_valid  out  1  issued micro-op valid
IS_out_pc, IS_out_inst, IS_out_imm  out  32 each  issued fields
IS_out_op  out  5; IS_out_f3  out  3; IS_out_f7  out  7
IS_out_P_rs1, IS_out_P_rs2, IS_out_P_rd  out  7 each
IS_out_fu_sel  out  3; IS_out_rob_idx  out  3
IS_out_LQ_tail, IS_out_SQ_tail  out  2 each; IS_out_jump  out  1

Behaviour:
- Reset: all entry valid bits 0, IS_count 0, IS_out_valid 0, all IS_out_* data 0; IS_ready 1 in first cycle after reset.
- Storage: compacting array, slot 0 oldest. Each entry holds all DC fields plus rdy1, rdy2.
- IS_ready = (IS_count < DEPTH) && !mispredict && !stall. Depends only on registered count and flush/hold inputs, never on same-cycle issue; full queue stays not-ready even if an issue occurs that cycle.
- Insert: when DC_valid && IS_ready, the micro-op is written at slot IS_count, or at IS_count-1 when an issue happens that same cycle.
- Insert readiness:
  - rdyN = !rsN_busy || P_rsN==0 || (any wb_valid[k] with wb_preg[k]==P_rsN).
  - Preg 0 is always ready.
- Wakeup: every cycle, each valid entry sets rdyN when any valid wb port matches its P_rsN. Duplicate matches are harmless.
- Readiness is registered: a wakeup at cycle t makes the entry selectable at t+1. There is no same-cycle wakeup-to-select bypass.
- Select: lowest slot index i with valid, rdy1, rdy2 and fu_ready[fu_sel[i]]. Evaluated on registered state only; an entry inserted at cycle t is selectable at t+1.
- Issue:
  - The selected entry is copied into the IS_out_* registers, IS_out_valid<=1, and slots above i shift down by one in the same edge.
  - With no selection, IS_out_valid<=0 and IS_out_* data hold their last values.
- Latency: a ready micro-op accepted at edge t, with its FU free, appears with IS_out_valid=1 after edge t+1 (issued at most one cycle after insert).
- IS_out_valid is a one-cycle pulse per issue. There is no downstream backpressure beyond fu_ready.
- IS_count_next = IS_count + insert - issue. It never exceeds DEPTH and never underflows.
- stall (no mispredict): no insert, no issue, no shift, IS_out_valid<=0. Wakeups are still applied.
- mispredict, which has priority over stall:
  - All entry valids clear, IS_count<=0, IS_out_valid<=0.
  - Insert and issue are suppressed that cycle.
  - IS_ready=1 from the next cycle.
- Reset asserted mid-operation: same effect as mispredict, plus output data zeroed.

Test Plan:
- Reset, then insert pc=0x100 add P_rs1=5 P_rs2=6, both busy=0, fu_ready=8'hFF -> IS_out_valid=1 with IS_out_pc=0x100 exactly two edges after insert; IS_count returns to 0.
- Fill 4 entries all with rs1_busy=1 (P_rs1=9) -> IS_ready=0, IS_count=4. Then wb_valid[0]=1, wb_preg=9 -> the next cycle issues slot 0 (oldest pc). Subsequent cycles issue in pc order; IS_ready=1 after the first issue edge.
- Slot0 fu_sel=2 with fu_ready[2]=0, slot1 fu_sel=0 ready -> slot1 issues first, slot0 stays in the queue and issues when fu_ready[2]=1.
- Insert with rs2_busy=1 while wb_preg[1]==P_rs2 is valid in the same cycle -> entry captured ready, issues next cycle; P_rs1=0 with rs1_busy=1 also treated as ready.
- 3 entries queued, assert mispredict for one cycle while DC_valid=1 -> IS_count=0, IS_out_valid=0 next cycle, the offered op is not inserted, IS_ready=1 afterward.
- stall held 3 cycles with ready entries and a wakeup in the middle -> no IS_out_valid during the stall. After release, woken entries issue oldest-first starting the first cycle.
